// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard stall unit and the EX forwarding unit.
package hazard_stall_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int PERF_W     = 32;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } miss_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/hazard_miss_watchdog.sv
// Tracks outstanding dcache misses and raises a sticky flag when one
// stalls the pipeline for MISS_TIMEOUT consecutive cycles.
module hazard_miss_watchdog
    import hazard_stall_unit_pkg::*;
#(
    parameter int MISS_TIMEOUT = 1000,
    parameter int CNT_W        = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic Mem_Stall_i,
    output logic Miss_Active_o,
    output logic Timeout_o
);

    miss_state_e      state_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic             timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            miss_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (Mem_Stall_i) begin
                        state_q    <= MISS;
                        miss_cnt_q <= CNT_W'(1);
                    end
                end
                MISS: begin
                    if (miss_cnt_q == CNT_W'(MISS_TIMEOUT))
                        timeout_q <= 1'b1;
                    if (Mem_Stall_i) begin
                        if (!(&miss_cnt_q))
                            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                    end else begin
                        state_q    <= RUN;
                        miss_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    miss_cnt_q <= '0;
                end
            endcase
        end
    end

    assign Miss_Active_o = (state_q == MISS);
    assign Timeout_o     = timeout_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use bubbles, branch flushes and dcache-miss freezes for the pipeline.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MISS_TIMEOUT = 1000,
    parameter int CNT_W        = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] ID_RSaddr1_i,
    input  logic [REG_ADDR_W-1:0] ID_RSaddr2_i,
    input  logic                  ID_UseRS2_i,
    input  logic                  EX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] EX_RDaddr_i,
    input  logic                  Branch_i,
    input  logic                  Mem_Stall_i,
    output logic                  PCWrite_o,
    output logic                  IFID_Write_o,
    output logic                  IFID_Flush_o,
    output logic                  NoOp_o,
    output logic                  Pipe_Stall_o,
    output logic                  Miss_Active_o,
    output logic                  Timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     LoadUse_Cnt_o,
    output logic [PERF_W-1:0]     MissStall_Cnt_o,
    output logic [PERF_W-1:0]     Flush_Cnt_o
`endif
);

    logic load_use;

    assign load_use = EX_MemRead_i
                   && (EX_RDaddr_i != '0)
                   && ((EX_RDaddr_i == ID_RSaddr1_i)
                    || (ID_UseRS2_i && (EX_RDaddr_i == ID_RSaddr2_i)));

    // A miss freezes ID too, so a pending load-use or branch re-presents later.
    always_comb begin
        PCWrite_o    = 1'b1;
        IFID_Write_o = 1'b1;
        IFID_Flush_o = 1'b0;
        NoOp_o       = 1'b0;
        Pipe_Stall_o = 1'b0;
        if (rst_i) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            IFID_Flush_o = 1'b1;
            NoOp_o       = 1'b1;
        end else if (Mem_Stall_i) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            Pipe_Stall_o = 1'b1;
        end else if (load_use) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            NoOp_o       = 1'b1;
        end else if (Branch_i) begin
            IFID_Flush_o = 1'b1;
        end
    end

    hazard_miss_watchdog #(
        .MISS_TIMEOUT (MISS_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_watchdog (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .Mem_Stall_i   (Mem_Stall_i),
        .Miss_Active_o (Miss_Active_o),
        .Timeout_o     (Timeout_o)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] lu_cnt_q;
    logic [PERF_W-1:0] ms_cnt_q;
    logic [PERF_W-1:0] fl_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lu_cnt_q <= '0;
            ms_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            if (load_use && !Mem_Stall_i)
                lu_cnt_q <= sat_inc(lu_cnt_q);
            if (Mem_Stall_i)
                ms_cnt_q <= sat_inc(ms_cnt_q);
            if (IFID_Flush_o)
                fl_cnt_q <= sat_inc(fl_cnt_q);
        end
    end

    assign LoadUse_Cnt_o   = lu_cnt_q;
    assign MissStall_Cnt_o = ms_cnt_q;
    assign Flush_Cnt_o     = fl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;
    logic       use2 = 1'b0;
    logic       mr = 1'b0;
    logic [4:0] rd = '0;
    logic       br = 1'b0;
    logic       ms = 1'b0;

    logic pcw, ifw, flush, noop, pst, mact, tout;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt, ms_cnt, fl_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // comb = {PCWrite, IFID_Write, IFID_Flush, NoOp, Pipe_Stall}
    // to: 0/1 expected Timeout_o, 2 = not checked; pz: perf counters zero
    typedef struct {
        string      nm;
        logic [4:0] comb;
        logic       ma;
        int         to;
        bit         pz;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .MISS_TIMEOUT (4),
        .CNT_W        (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ID_RSaddr1_i  (rs1),
        .ID_RSaddr2_i  (rs2),
        .ID_UseRS2_i   (use2),
        .EX_MemRead_i  (mr),
        .EX_RDaddr_i   (rd),
        .Branch_i      (br),
        .Mem_Stall_i   (ms),
        .PCWrite_o     (pcw),
        .IFID_Write_o  (ifw),
        .IFID_Flush_o  (flush),
        .NoOp_o        (noop),
        .Pipe_Stall_o  (pst),
        .Miss_Active_o (mact),
        .Timeout_o     (tout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .LoadUse_Cnt_o   (lu_cnt),
        .MissStall_Cnt_o (ms_cnt),
        .Flush_Cnt_o     (fl_cnt)
`endif
    );

    task automatic vec(input string nm, input logic r,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic u2, input logic m, input logic [4:0] d,
                       input logic b, input logic s,
                       input logic [4:0] ec, input logic ema,
                       input int eto, input bit epz = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; rs1 = a1; rs2 = a2; use2 = u2;
        mr = m; rd = d; br = b; ms = s;
        e.nm = nm; e.comb = ec; e.ma = ema; e.to = eto; e.pz = epz;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [4:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {pcw, ifw, flush, noop, pst};
                total++;
                if (got !== e.comb) begin
                    bad++;
                    $display("FAIL %s ctrl: got %b want %b", e.nm, got, e.comb);
                end
                total++;
                if (mact !== e.ma) begin
                    bad++;
                    $display("FAIL %s miss_active: got %b want %b", e.nm, mact, e.ma);
                end
                if (e.to != 2) begin
                    total++;
                    if (tout !== e.to[0]) begin
                        bad++;
                        $display("FAIL %s timeout: got %b want %b", e.nm, tout, e.to[0]);
                    end
                end
`ifdef HAZARD_PERF_CNT_EN
                if (e.pz) begin
                    total++;
                    if ({lu_cnt, ms_cnt, fl_cnt} !== '0) begin
                        bad++;
                        $display("FAIL %s perf: got %0d/%0d/%0d want 0/0/0",
                                 e.nm, lu_cnt, ms_cnt, fl_cnt);
                    end
                end
`endif
            end
        end
    end

    localparam logic [4:0] DEF = 5'b11000;
    localparam logic [4:0] RST = 5'b00110;
    localparam logic [4:0] LU  = 5'b00010;
    localparam logic [4:0] BR  = 5'b11100;
    localparam logic [4:0] MS  = 5'b00001;

    initial begin : driver
        //    name        rst rs1 rs2 u2 mr rd br ms  ctrl ma to pz
        vec("reset0",    1, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
        vec("reset1",    1, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, 1);
        vec("idle",      0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 1);
        vec("lu_rs1",    0, 5, 7, 1, 1, 5, 0, 0, LU,  0, 0);
        vec("lu_bubble", 0, 5, 7, 1, 0, 0, 0, 0, DEF, 0, 0);
        vec("lw_x0",     0, 0, 0, 1, 1, 0, 0, 0, DEF, 0, 0);
        vec("rs2_nouse", 0, 1, 5, 0, 1, 5, 0, 0, DEF, 0, 0);
        vec("rs2_use",   0, 1, 5, 1, 1, 5, 0, 0, LU,  0, 0);
        vec("br_plain",  0, 1, 2, 1, 0, 0, 1, 0, BR,  0, 0);
        vec("br_lu",     0, 5, 2, 1, 1, 5, 1, 0, LU,  0, 0);
        vec("br_after",  0, 5, 2, 1, 0, 0, 1, 0, BR,  0, 0);
        for (int i = 1; i <= 8; i++)
            vec($sformatf("miss8_%0d", i), 0, 5, 2, 1, 1, 5, 1, 1, MS,
                i > 1, (i <= 4) ? 0 : (i == 5) ? 2 : 1);
        vec("miss8_rel1", 0, 5, 2, 1, 1, 5, 1, 0, LU,  1, 1);
        vec("miss8_rel2", 0, 5, 2, 1, 0, 0, 1, 0, BR,  0, 1);
        vec("to_rst",     1, 0, 0, 0, 0, 0, 0, 0, RST, 0, 1);
        vec("to_clr",     0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 1);
        for (int i = 1; i <= 6; i++)
            vec($sformatf("miss6_%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, MS,
                i > 1, (i <= 4) ? 0 : (i == 5) ? 2 : 1);
        vec("miss6_rel1", 0, 0, 0, 0, 0, 0, 0, 0, DEF, 1, 1);
        vec("miss6_rel2", 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1);
        vec("miss6_rel3", 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1);
        vec("miss6_rst",  1, 0, 0, 0, 0, 0, 0, 0, RST, 0, 1);
        vec("miss6_clr",  0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0);
        vec("rr_a1",      0, 0, 0, 0, 0, 0, 0, 1, MS,  0, 0);
        vec("rr_a2",      0, 0, 0, 0, 0, 0, 0, 1, MS,  1, 0);
        vec("rr_a3",      0, 0, 0, 0, 0, 0, 0, 1, MS,  1, 0);
        vec("rr_gap",     0, 0, 0, 0, 0, 0, 0, 0, DEF, 1, 0);
        vec("rr_b1",      0, 0, 0, 0, 0, 0, 0, 1, MS,  0, 0);
        vec("rr_b2",      0, 0, 0, 0, 0, 0, 0, 1, MS,  1, 0);
        vec("rr_b3",      0, 0, 0, 0, 0, 0, 0, 1, MS,  1, 0);
        vec("rr_end1",    0, 0, 0, 0, 0, 0, 0, 0, DEF, 1, 0);
        vec("rr_end2",    0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0);
        vec("mid_m1",     0, 0, 0, 0, 0, 0, 0, 1, MS,  0, 0);
        vec("mid_m2",     0, 0, 0, 0, 0, 0, 0, 1, MS,  1, 0);
        vec("mid_rst",    1, 0, 0, 0, 0, 0, 0, 1, RST, 1, 0);
        vec("mid_post",   0, 0, 0, 0, 0, 0, 0, 1, MS,  0, 0, 1);
        vec("mid_remiss", 0, 0, 0, 0, 0, 0, 0, 1, MS,  1, 0);
        vec("mid_rel",    0, 0, 0, 0, 0, 0, 0, 0, DEF, 1, 0);
        vec("mid_idle",   0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of EX-stage operand forwarding for the 5-stage RISC-V pipeline with data cache.
- Forwarding covers every RAW case except a load immediately followed by a consumer; this block creates the conditions forwarding relies on.
- Inserts load-use bubbles, flushes IF/ID on taken branches, and freezes the whole pipeline while the dcache services a miss.
- Adds a sequential miss tracker with a timeout watchdog. Sits in the top-level CPU next to the forwarding unit; drives PC, IF/ID, ID/EX and all later pipeline registers.

Parameters:
- MISS_TIMEOUT, 1000, number of consecutive miss-stall cycles after which the timeout flag sets.
- CNT_W, 10, width of the miss cycle counter; must satisfy 2**CNT_W > MISS_TIMEOUT.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- ID_RSaddr1_i  input  5  rs1 of the instruction in ID.
- ID_RSaddr2_i  input  5  rs2 of the instruction in ID.
- ID_UseRS2_i  input  1  ID instruction reads rs2 (R/S/B types).
- EX_MemRead_i  input  1  instruction in EX is a load.
- EX_RDaddr_i  input  5  rd of the instruction in EX.
- Branch_i  input  1  taken branch resolved in ID this cycle.
- Mem_Stall_i  input  1  dcache miss outstanding; high until the data is ready.
- PCWrite_o  output  1  PC update enable.
- IFID_Write_o  output  1  IF/ID register update enable.
- IFID_Flush_o  output  1  load NOP into IF/ID.
- NoOp_o  output  1  zero control signals into ID/EX (bubble).
- Pipe_Stall_o  output  1  freeze ID/EX, EX/MEM, MEM/WB.
- Miss_Active_o  output  1  registered; FSM is in MISS.
- Timeout_o  output  1  registered, sticky miss-timeout flag.

Behaviour:
- load_use = EX_MemRead_i && EX_RDaddr_i!=0 && (EX_RDaddr_i==ID_RSaddr1_i || (ID_UseRS2_i && EX_RDaddr_i==ID_RSaddr2_i)).
- Outputs are combinational, evaluated in the same cycle with zero latency. Priority, highest first:
  - rst_i: PCWrite_o=0, IFID_Write_o=0, IFID_Flush_o=1, NoOp_o=1, Pipe_Stall_o=0.
  - Mem_Stall_i: PCWrite_o=0, IFID_Write_o=0, Pipe_Stall_o=1, NoOp_o=0, IFID_Flush_o=0. Branch_i and load_use are ignored; ID stays frozen, so both re-present after release.
  - load_use: PCWrite_o=0, IFID_Write_o=0, NoOp_o=1, IFID_Flush_o=0. A branch in ID depending on the load is not flushed this cycle.
  - Branch_i: IFID_Flush_o=1, PCWrite_o=1, IFID_Write_o=1.
  - default: PCWrite_o=1, IFID_Write_o=1, all others 0.
- FSM states: RUN (reset), MISS.
  - RUN -> MISS when Mem_Stall_i=1, with miss_cnt<=1.
  - MISS: while Mem_Stall_i=1, miss_cnt increments and saturates at 2**CNT_W-1.
  - MISS -> RUN when Mem_Stall_i=0, with miss_cnt<=0.
  - A stall that drops then re-rises in consecutive cycles spends exactly 1 cycle in RUN, then re-enters MISS with the count restarted.
- Miss_Active_o = (state==MISS). It lags Mem_Stall_i by one cycle.
- Timeout_o sets on the edge where miss_cnt==MISS_TIMEOUT while still in MISS. It stays set until rst_i and does not alter stall outputs.
- Reset: state=RUN, miss_cnt=0, Miss_Active_o=0, Timeout_o=0. Reset mid-miss aborts tracking immediately. If Mem_Stall_i is still high the cycle after reset deasserts, the FSM re-enters MISS.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN adds three 32-bit saturating output counters, all reset to 0 by rst_i:
  - LoadUse_Cnt_o: +1 per cycle where NoOp_o=1 due to load_use.
  - MissStall_Cnt_o: +1 per cycle where Mem_Stall_i=1.
  - Flush_Cnt_o: +1 per cycle where IFID_Flush_o=1 outside reset.
- Without the macro these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5.
  - FSM state encoding (RUN=1'b0, MISS=1'b1).
  - Forward-select codes (2'b00 regfile, 2'b01 WB, 2'b10 MEM), so this block and the forwarding unit share one source.
- One sub-module, hazard_miss_watchdog: the FSM, miss_cnt and Timeout_o. It takes clk_i, rst_i and Mem_Stall_i and outputs Miss_Active_o and Timeout_o.

Test Plan:
- EX lw x5, ID add x6,x5,x7 (rs1=5) -> one cycle PCWrite_o=0, IFID_Write_o=0, NoOp_o=1. Next cycle EX holds a bubble and outputs return to default.
- EX lw x0, ID rs1=0 -> no stall. EX lw x5, ID rs2=5 with ID_UseRS2_i=0 -> no stall.
- Branch_i=1 with no hazard -> IFID_Flush_o=1, PCWrite_o=1. Branch_i=1 with load_use on rs1 -> NoOp_o=1, IFID_Flush_o=0, then the flush occurs the following cycle.
- Mem_Stall_i high 8 cycles alongside load_use and Branch_i -> Pipe_Stall_o=1 for 8 cycles, NoOp_o=0, IFID_Flush_o=0. Miss_Active_o high cycles 2-9. Stall then load-use priority resumes.
- MISS_TIMEOUT=4, Mem_Stall_i held 6 cycles -> Timeout_o rises after the 4th MISS count and stays high after the stall ends. rst_i pulse clears it.
- rst_i asserted mid-miss -> next cycle state=RUN, Miss_Active_o=0, and during reset IFID_Flush_o=1, NoOp_o=1. With HAZARD_PERF_CNT_EN, all counters read 0 after reset.
